qtz_batch_sched: RTL and testbench
==================================

Name: qtz_batch_sched

Overview:
- Batch scheduler that sequences the quantizing/item-memory mapping stage over a stream of samples.
- Per sample, in order:
  - accepts the sample's feature values on a valid/ready input handshake and pulses a register-load strobe;
  - fires one start_mapping pulse into the mapping stage and waits for mapping_done;
  - presents the mapped level hypervectors downstream on a valid/ready output handshake.
- Counts samples against a programmed batch size and signals batch completion. Sits between the sample source, the quantizing stage and the encoder.

Parameters:
- BATCH_W, 8, width of batch_size and sample_idx (max batch 2^BATCH_W-1)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles spent in WAIT (used only with QTZ_SCHED_WATCHDOG_EN)

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- en  input  1  global enable; low freezes all state
- batch_start  input  1  request a new batch; honoured only in IDLE
- batch_size  input  BATCH_W  samples per batch, captured on accepted batch_start
- batch_abort  input  1  synchronous abort to IDLE
- in_valid  input  1  source has a sample on input_values
- in_ready  output  1  scheduler accepts a sample this cycle
- in_load  output  1  one-cycle strobe: capture input_values into mapping input register
- start_mapping  output  1  one-cycle start pulse to the mapping stage
- mapping_done  input  1  mapping stage finished current sample
- out_valid  output  1  mapped level HVs valid downstream
- out_ready  input  1  downstream accepts
- sample_idx  output  BATCH_W  index of current sample in batch
- busy  output  1  high in any state other than IDLE
- batch_done  output  1  one-cycle pulse on last sample's output handshake
- timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (nrst low, async):
  - state=IDLE;
  - sample_idx=0, latched size=0, watchdog counter=0;
  - all outputs 0.
- en=0:
  - no state, counter or register changes;
  - in_ready, out_valid, in_load, start_mapping and batch_done forced 0;
  - inputs ignored, including batch_abort and mapping_done.
- All rules below apply only with en=1.
- IDLE:
  - batch_start=1 with batch_size!=0: latch size, sample_idx=0, clear timeout, go to ACCEPT.
  - batch_start with batch_size==0: ignored.
- ACCEPT:
  - in_ready=1.
  - On in_valid & in_ready: in_load=1 in the same cycle, go to START.
- START:
  - start_mapping=1 for exactly this cycle, go to WAIT.
- WAIT:
  - On mapping_done: go to OUTPUT. mapping_done may arrive as early as the cycle after START.
  - mapping_done in any state other than WAIT is ignored.
- OUTPUT:
  - out_valid=1, held until out_ready.
  - On handshake with sample_idx==size-1: batch_done=1 that cycle, sample_idx=0, go to IDLE.
  - On handshake otherwise: sample_idx+1, go to ACCEPT.
- Latency:
  - input handshake at cycle N: start_mapping at N+1;
  - mapping_done at cycle M: out_valid at M+1;
  - output handshake at cycle K: in_ready at K+1.
- batch_abort (any non-IDLE state):
  - next state IDLE, sample_idx=0;
  - no batch_done, no in_load/start_mapping/out handshake that cycle;
  - a late mapping_done after the abort is ignored.
- Simultaneous events:
  - batch_abort has priority over every handshake and over mapping_done.
  - batch_start while busy is ignored.
- Size 1 batch: one sample; batch_done coincides with its output handshake.
- sample_idx never exceeds size-1; no wrap-around within a batch.
- busy is registered from state; all pulse outputs are combinational from state and inputs.

Optional Feature:
- Macro QTZ_SCHED_WATCHDOG_EN.
- Defined:
  - a counter runs while in WAIT, cleared on WAIT entry.
  - If TIMEOUT_CYCLES cycles elapse in WAIT without mapping_done, set timeout=1 and go to IDLE with sample_idx=0 and no batch_done.
  - timeout stays set until the next accepted batch_start.
  - mapping_done on the same cycle as expiry wins: no timeout.
- Undefined:
  - timeout tied to 0, no counter; WAIT persists indefinitely.

Test Plan:
- Reset mid-batch, asserted in WAIT: all outputs 0 and busy=0 immediately; a later mapping_done is ignored.
- batch_size=3, source always valid, mapping_done 2 cycles after each start_mapping, out_ready always 1: three in_load/start_mapping pairs, sample_idx 0,1,2, one batch_done on the third output handshake, then IDLE.
- batch_size=2, out_ready low for 5 cycles on sample 0: out_valid held 5 cycles, in_ready stays 0, sample_idx stays 0 until the handshake.
- batch_size=0 batch_start: stays IDLE, busy=0. Then batch_start with size=4 while busy in WAIT: ignored, batch continues.
- batch_abort in WAIT and mapping_done in the same cycle: IDLE next cycle, no out_valid, no batch_done. en=0 for 3 cycles in OUTPUT: out_valid 0, state retained, handshake completes after en returns.
- With QTZ_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=8, mapping_done never asserted: timeout=1 after 8 WAIT cycles, IDLE. A new batch_start clears timeout.

Source files
------------

// File: rtl/qtz_batch_sched.sv
// qtz_batch_sched: per-sample accept/map/output sequencer for the quantizing stage over a batch.
// Optional WAIT watchdog enabled by defining QTZ_SCHED_WATCHDOG_EN.
module qtz_batch_sched #(
  parameter int BATCH_W        = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               batch_start,
  input  logic [BATCH_W-1:0] batch_size,
  input  logic               batch_abort,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               in_load,
  output logic               start_mapping,
  input  logic               mapping_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BATCH_W-1:0] sample_idx,
  output logic               busy,
  output logic               batch_done,
  output logic               timeout
);
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_START, S_WAIT, S_OUTPUT} state_e;
  state_e state_q, state_d;
  logic [BATCH_W-1:0] idx_q, idx_d, size_q, size_d;
  logic busy_q, last, out_hs, abort;
`ifdef QTZ_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic tmo_q, tmo_d, expire;
  assign expire  = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif
  assign abort      = en && batch_abort && state_q != S_IDLE;
  assign last       = idx_q == size_q - 1'b1;
  assign in_ready   = en && !batch_abort && state_q == S_ACCEPT;
  assign in_load    = in_ready && in_valid;
  assign start_mapping = en && !batch_abort && state_q == S_START;
  assign out_valid  = en && !batch_abort && state_q == S_OUTPUT;
  assign out_hs     = out_valid && out_ready;
  assign batch_done = out_hs && last;
  assign sample_idx = idx_q;
  assign busy       = busy_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    size_d  = size_q;
`ifdef QTZ_SCHED_WATCHDOG_EN
    tmo_d   = tmo_q;
    wd_d    = wd_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else if (en) begin
      case (state_q)
        S_IDLE: if (batch_start && batch_size != '0) begin
          state_d = S_ACCEPT;
          size_d  = batch_size;
          idx_d   = '0;
`ifdef QTZ_SCHED_WATCHDOG_EN
          tmo_d   = 1'b0;
`endif
        end
        S_ACCEPT: state_d = in_load ? S_START : S_ACCEPT;
        S_START:  state_d = S_WAIT;
        S_WAIT: begin
          state_d = mapping_done ? S_OUTPUT : S_WAIT;
`ifdef QTZ_SCHED_WATCHDOG_EN
          // mapping_done on the expiry cycle takes precedence over the timeout
          if (!mapping_done && expire) begin
            state_d = S_IDLE;
            idx_d   = '0;
            tmo_d   = 1'b1;
          end
`endif
        end
        S_OUTPUT: if (out_hs) begin
          state_d = last ? S_IDLE : S_ACCEPT;
          idx_d   = last ? '0 : idx_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
`ifdef QTZ_SCHED_WATCHDOG_EN
      wd_d = (state_q == S_WAIT && state_d == S_WAIT) ? wd_q + 1'b1 : '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      busy_q  <= 1'b0;
`ifdef QTZ_SCHED_WATCHDOG_EN
      tmo_q   <= 1'b0;
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      busy_q  <= state_d != S_IDLE;
`ifdef QTZ_SCHED_WATCHDOG_EN
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
`endif
    end
  end
endmodule

// File: tb/tb_qtz_batch_sched.sv
// tb_qtz_batch_sched: directed bench with an expected-output scoreboard for qtz_batch_sched.
module tb_qtz_batch_sched;
  localparam int BW = 8;
  logic clk = 1'b0, nrst = 1'b1, en = 1'b0, batch_start = 1'b0, batch_abort = 1'b0;
  logic in_valid = 1'b0, mapping_done = 1'b0, out_ready = 1'b0;
  logic [BW-1:0] batch_size = '0;
  logic in_ready, in_load, start_mapping, out_valid, busy, batch_done, timeout;
  logic [BW-1:0] sample_idx;
  typedef struct {logic [BW-1:0] idx; logic last;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, m_acc = 0, m_size = 0;
  always #5 clk = ~clk;
  qtz_batch_sched #(.BATCH_W(BW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .batch_start(batch_start), .batch_size(batch_size),
    .batch_abort(batch_abort), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .start_mapping(start_mapping), .mapping_done(mapping_done), .out_valid(out_valid),
    .out_ready(out_ready), .sample_idx(sample_idx), .busy(busy), .batch_done(batch_done),
    .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one call per cycle: settles comb outputs, then feeds/drains the scoreboard
  task automatic settle;
    exp_t e;
    #1;
    if (in_load) begin
      sb.push_back('{idx: BW'(m_acc), last: (m_acc == m_size - 1)});
      m_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("out_idx", sample_idx, e.idx);
        chk("batch_done", batch_done, e.last);
      end
    end else chk("no_batch_done", batch_done, 0);
  endtask
  task automatic adv;
    @(negedge clk);
  endtask
  task automatic new_batch(input int sz);
    batch_start = 1'b1; batch_size = BW'(sz);
    settle; chk("idle_busy", busy, 0); adv;
    batch_start = 1'b0; m_size = sz; m_acc = 0;
    settle; chk("acc_busy", busy, 1);
  endtask
  task automatic do_sample(input int dly, input int stall);
    in_valid = 1'b1;
    settle; chk("acc_ready", in_ready, 1); chk("acc_load", in_load, 1); adv;
    in_valid = 1'b0;
    settle; chk("start", start_mapping, 1); chk("start_ready", in_ready, 0); adv;
    for (int i = 0; i < dly - 1; i++) begin
      settle; chk("wait_ov", out_valid, 0); chk("wait_start", start_mapping, 0); adv;
    end
    mapping_done = 1'b1;
    settle; chk("done_ov", out_valid, 0); adv;
    mapping_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      settle; chk("stall_ov", out_valid, 1); chk("stall_ready", in_ready, 0);
      chk("stall_idx", sample_idx, m_acc - 1); adv;
    end
    out_ready = 1'b1;
    settle; chk("hs_ov", out_valid, 1); adv;
    out_ready = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
  initial begin
    en = 1'b1;
    #1 nrst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0); chk("rst_load", in_load, 0); chk("rst_start", start_mapping, 0);
    chk("rst_ov", out_valid, 0); chk("rst_idx", sample_idx, 0); chk("rst_busy", busy, 0);
    chk("rst_bd", batch_done, 0); chk("rst_tmo", timeout, 0);
    adv; nrst = 1'b1; adv;
    // size 3, always-valid source, done 2 cycles after start
    new_batch(3); adv;
    repeat (3) do_sample(2, 0);
    settle; chk("b3_idle", busy, 0); chk("b3_ready", in_ready, 0); adv;
    // size 2 with a 5-cycle output stall on sample 0
    new_batch(2); adv;
    do_sample(2, 5);
    do_sample(1, 0);
    settle; chk("b2_idle", busy, 0); adv;
    // size 0 ignored; batch_start while busy ignored
    batch_size = '0; batch_start = 1'b1; settle; adv; batch_start = 1'b0;
    settle; chk("sz0_busy", busy, 0); chk("sz0_ready", in_ready, 0); adv;
    new_batch(2); adv;
    batch_start = 1'b1; batch_size = 8'd4;
    do_sample(3, 0);
    batch_start = 1'b0;
    do_sample(2, 0);
    settle; chk("busy_start_idle", busy, 0); adv;
    // abort in WAIT coinciding with mapping_done
    new_batch(2); adv;
    in_valid = 1'b1; settle; adv; in_valid = 1'b0;
    settle; adv;
    batch_abort = 1'b1; mapping_done = 1'b1;
    settle; chk("abort_ov", out_valid, 0); adv;
    batch_abort = 1'b0; mapping_done = 1'b0; sb.delete();
    settle; chk("abort_busy", busy, 0); chk("abort_ov2", out_valid, 0); chk("abort_idx", sample_idx, 0); adv;
    mapping_done = 1'b1; settle; adv; mapping_done = 1'b0;
    settle; chk("late_done_busy", busy, 0); chk("late_done_ov", out_valid, 0); adv;
    // en low for 3 cycles while in OUTPUT
    new_batch(1); adv;
    in_valid = 1'b1; settle; adv; in_valid = 1'b0;
    settle; adv;
    mapping_done = 1'b1; settle; adv; mapping_done = 1'b0;
    en = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      settle; chk("en0_ov", out_valid, 0); chk("en0_busy", busy, 1); chk("en0_ready", in_ready, 0); adv;
    end
    en = 1'b1;
    settle; chk("en1_ov", out_valid, 1); adv;
    out_ready = 1'b0;
    settle; chk("en1_idle", busy, 0); adv;
    // async reset while in WAIT
    new_batch(2); adv;
    in_valid = 1'b1; settle; adv; in_valid = 1'b0;
    settle; adv;
    #2 nrst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_ov", out_valid, 0); chk("mrst_ready", in_ready, 0);
    chk("mrst_start", start_mapping, 0); chk("mrst_idx", sample_idx, 0);
    adv; nrst = 1'b1; sb.delete();
    mapping_done = 1'b1; settle; chk("mrst_done_ov", out_valid, 0); adv; mapping_done = 1'b0;
    settle; chk("mrst_done_busy", busy, 0); chk("mrst_done_ov2", out_valid, 0); adv;
`ifdef QTZ_SCHED_WATCHDOG_EN
    new_batch(1); adv;
    in_valid = 1'b1; settle; adv; in_valid = 1'b0;
    settle; adv;
    repeat (8) begin
      settle; chk("wd_busy", busy, 1); chk("wd_tmo", timeout, 0); adv;
    end
    settle; chk("wd_idle", busy, 0); chk("wd_set", timeout, 1); chk("wd_idx", sample_idx, 0); adv;
    sb.delete();
    new_batch(1); chk("wd_clear", timeout, 0); adv;
`else
    new_batch(1); adv;
    in_valid = 1'b1; settle; adv; in_valid = 1'b0;
    settle; adv;
    repeat (20) begin
      settle; chk("nowd_busy", busy, 1); chk("nowd_tmo", timeout, 0); chk("nowd_ov", out_valid, 0); adv;
    end
`endif
    batch_abort = 1'b1; settle; adv; batch_abort = 1'b0; sb.delete();
    settle; chk("final_idle", busy, 0); adv;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
